// File: rtl/flags_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : flags_pkg                                                 |
// | Purpose  : Flag bit positions and branch condition-code encodings    |
// |            shared by the flags context unit and its stack.           |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package flags_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_S = 3;

  localparam logic [3:0] COND_AL = 4'd0;
  localparam logic [3:0] COND_EQ = 4'd1;
  localparam logic [3:0] COND_NE = 4'd2;
  localparam logic [3:0] COND_CS = 4'd3;
  localparam logic [3:0] COND_CC = 4'd4;
  localparam logic [3:0] COND_MI = 4'd5;
  localparam logic [3:0] COND_PL = 4'd6;
  localparam logic [3:0] COND_VS = 4'd7;
  localparam logic [3:0] COND_VC = 4'd8;
  localparam logic [3:0] COND_HI = 4'd9;
  localparam logic [3:0] COND_LS = 4'd10;
  localparam logic [3:0] COND_GE = 4'd11;
  localparam logic [3:0] COND_LT = 4'd12;
  localparam logic [3:0] COND_GT = 4'd13;
  localparam logic [3:0] COND_LE = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

endpackage
`default_nettype wire

// File: rtl/flags_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : flags_stack                                               |
// | Purpose  : LIFO shadow stack of flag words with depth/full/empty.    |
// |            Strobes arrive already qualified against full/empty.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module flags_stack #(
  parameter int NFLAGS      = 4,
  parameter int STACK_DEPTH = 4,
  parameter int PTR_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [NFLAGS-1:0] i_din,
  output logic [NFLAGS-1:0] o_top,
  output logic [PTR_W-1:0]  o_depth,
  output logic              o_full,
  output logic              o_empty
);

  localparam logic [PTR_W-1:0] c_one = PTR_W'(1);
  localparam logic [PTR_W-1:0] c_max = PTR_W'(STACK_DEPTH);

  logic [PTR_W-1:0]  r_depth;
  logic [NFLAGS-1:0] r_mem [STACK_DEPTH];
  logic [NFLAGS-1:0] w_top;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_depth <= '0;
    end else if (i_push) begin
      r_depth <= r_depth + c_one;
    end else if (i_pop) begin
      r_depth <= r_depth - c_one;
    end
  end

  // Entries are not reset; only slots below depth are ever observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (i_push && (r_depth == PTR_W'(i))) begin
        r_mem[i] <= i_din;
      end
    end
  end

  always_comb begin
    w_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (r_depth == PTR_W'(i + 1)) begin
        w_top = r_mem[i];
      end
    end
  end

  assign o_top   = w_top;
  assign o_depth = r_depth;
  assign o_full  = (r_depth == c_max);
  assign o_empty = (r_depth == '0);

endmodule
`default_nettype wire

// File: rtl/flags_context_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : flags_context_unit                                        |
// | Purpose  : Masked flag register with save/restore stack, sticky      |
// |            stack errors and branch condition evaluation.             |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module flags_context_unit
  import flags_pkg::*;
#(
  parameter int NFLAGS      = 4,
  parameter int STACK_DEPTH = 4,
  localparam int PTR_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              update,
  input  logic [NFLAGS-1:0] upd_mask,
  input  logic [NFLAGS-1:0] flags_in,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  input  logic [3:0]        cond,
  output logic [NFLAGS-1:0] flags,
  output logic              cond_true,
  output logic [PTR_W-1:0]  depth,
  output logic              full,
  output logic              empty,
  output logic              err_overflow,
  output logic              err_underflow
);

  logic [NFLAGS-1:0] r_flags;
  logic [NFLAGS-1:0] w_flags_nxt;
  logic [NFLAGS-1:0] w_top;
  logic [PTR_W-1:0]  w_depth;
  logic              w_full;
  logic              w_empty;
  logic              r_err_ovf;
  logic              r_err_unf;
  logic              w_push_req;
  logic              w_pop_req;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic              w_ovf_evt;
  logic              w_unf_evt;
  logic              w_cond;
  logic              w_z;
  logic              w_c;
  logic              w_v;
  logic              w_s;

  // Simultaneous push and pop cancel each other entirely.
  assign w_push_req = push & ~pop;
  assign w_pop_req  = pop & ~push;
  assign w_push_ok  = w_push_req & ~w_full;
  assign w_pop_ok   = w_pop_req & ~w_empty;
  assign w_ovf_evt  = w_push_req & w_full;
  assign w_unf_evt  = w_pop_req & w_empty;

  flags_stack #(
    .NFLAGS      (NFLAGS),
    .STACK_DEPTH (STACK_DEPTH),
    .PTR_W       (PTR_W)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push_ok),
    .i_pop   (w_pop_ok),
    .i_din   (r_flags),
    .o_top   (w_top),
    .o_depth (w_depth),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A successful restore overrides any ALU update in the same cycle.
  always_comb begin
    w_flags_nxt = r_flags;
    if (update) begin
      w_flags_nxt = (r_flags & ~upd_mask) | (flags_in & upd_mask);
    end
    if (w_pop_ok) begin
      w_flags_nxt = w_top;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= '0;
    end else begin
      r_flags <= w_flags_nxt;
    end
  end

  // Error events take precedence over a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      if (w_ovf_evt) begin
        r_err_ovf <= 1'b1;
      end else if (err_clr) begin
        r_err_ovf <= 1'b0;
      end
      if (w_unf_evt) begin
        r_err_unf <= 1'b1;
      end else if (err_clr) begin
        r_err_unf <= 1'b0;
      end
    end
  end

  assign w_z = r_flags[FLAG_Z];
  assign w_c = r_flags[FLAG_C];
  assign w_v = r_flags[FLAG_V];
  assign w_s = r_flags[FLAG_S];

  always_comb begin
    w_cond = 1'b0;
    case (cond)
      COND_AL: w_cond = 1'b1;
      COND_EQ: w_cond = w_z;
      COND_NE: w_cond = ~w_z;
      COND_CS: w_cond = w_c;
      COND_CC: w_cond = ~w_c;
      COND_MI: w_cond = w_s;
      COND_PL: w_cond = ~w_s;
      COND_VS: w_cond = w_v;
      COND_VC: w_cond = ~w_v;
      COND_HI: w_cond = w_c & ~w_z;
      COND_LS: w_cond = ~w_c | w_z;
      COND_GE: w_cond = ~(w_s ^ w_v);
      COND_LT: w_cond = w_s ^ w_v;
      COND_GT: w_cond = ~w_z & ~(w_s ^ w_v);
      COND_LE: w_cond = w_z | (w_s ^ w_v);
      COND_NV: w_cond = 1'b0;
      default: w_cond = 1'b0;
    endcase
  end

  assign flags         = r_flags;
  assign cond_true     = w_cond;
  assign depth         = w_depth;
  assign full          = w_full;
  assign empty         = w_empty;
  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_unf;

endmodule
`default_nettype wire

// File: tb/tb_flags_context_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_flags_context_unit                                     |
// | Purpose  : Directed bench with a queue-based reference model.        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_flags_context_unit;

  localparam int NF = 4;
  localparam int SD = 4;
  localparam int PW = $clog2(SD + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          update = 1'b0;
  logic [NF-1:0] upd_mask = '0;
  logic [NF-1:0] flags_in = '0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          err_clr = 1'b0;
  logic [3:0]    cond = 4'd0;
  logic [NF-1:0] flags;
  logic          cond_true;
  logic [PW-1:0] depth;
  logic          full;
  logic          empty;
  logic          err_overflow;
  logic          err_underflow;

  int checks = 0;
  int errors = 0;

  flags_context_unit #(.NFLAGS(NF), .STACK_DEPTH(SD)) dut (
    .clk           (clk),
    .reset         (reset),
    .update        (update),
    .upd_mask      (upd_mask),
    .flags_in      (flags_in),
    .push          (push),
    .pop           (pop),
    .err_clr       (err_clr),
    .cond          (cond),
    .flags         (flags),
    .cond_true     (cond_true),
    .depth         (depth),
    .full          (full),
    .empty         (empty),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  // Reference model: flags word, stack as a queue, two sticky bits.
  logic [NF-1:0] m_flags = '0;
  logic [NF-1:0] m_stk[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  function automatic logic exp_cond(input logic [3:0] c, input logic [NF-1:0] f);
    logic z, cy, v, s;
    z = f[0]; cy = f[1]; v = f[2]; s = f[3];
    case (c)
      4'd0:  return 1'b1;
      4'd1:  return z;
      4'd2:  return !z;
      4'd3:  return cy;
      4'd4:  return !cy;
      4'd5:  return s;
      4'd6:  return !s;
      4'd7:  return v;
      4'd8:  return !v;
      4'd9:  return cy && !z;
      4'd10: return !cy || z;
      4'd11: return s == v;
      4'd12: return s != v;
      4'd13: return !z && (s == v);
      4'd14: return z || (s != v);
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_flags = '0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      logic [NF-1:0] nf;
      logic          do_push, do_pop, ovf_evt, unf_evt;
      do_push = push && !pop;
      do_pop  = pop && !push;
      ovf_evt = do_push && (m_stk.size() == SD);
      unf_evt = do_pop && (m_stk.size() == 0);
      nf = m_flags;
      if (update) nf = (m_flags & ~upd_mask) | (flags_in & upd_mask);
      if (do_push && !ovf_evt) m_stk.push_back(m_flags);
      if (do_pop && !unf_evt) nf = m_stk.pop_back();
      m_flags = nf;
      if (ovf_evt) m_ovf = 1'b1; else if (err_clr) m_ovf = 1'b0;
      if (unf_evt) m_unf = 1'b1; else if (err_clr) m_unf = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, mid-cycle.
  always @(negedge clk) begin
    chk("flags", 32'(flags), 32'(m_flags));
    chk("depth", 32'(depth), 32'(m_stk.size()));
    chk("full", 32'(full), 32'(m_stk.size() == SD));
    chk("empty", 32'(empty), 32'(m_stk.size() == 0));
    chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
    chk("err_underflow", 32'(err_underflow), 32'(m_unf));
    chk("cond_true", 32'(cond_true), 32'(exp_cond(cond, m_flags)));
  end

  // Apply one command for exactly one rising edge; returns just after it.
  task automatic drive(input logic u, input logic [NF-1:0] m, input logic [NF-1:0] fi,
                       input logic ps, input logic pp, input logic ec, input logic [3:0] c);
    update = u; upd_mask = m; flags_in = fi;
    push = ps; pop = pp; err_clr = ec; cond = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [3:0] c);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, c);
  endtask

  initial begin
    #1 reset = 1'b0;
    #2;
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;

    // 1: full write then EQ/NE
    drive(1'b1, 4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("t1_flags", 32'(flags), 32'h1);
    idle(4'd1);
    chk("t1_eq", 32'(cond_true), 32'h1);
    idle(4'd2);
    chk("t1_ne", 32'(cond_true), 32'h0);

    // 2: masked write
    drive(1'b1, 4'b0110, 4'b1110, 1'b0, 1'b0, 1'b0, 4'd3);
    chk("t2_flags", 32'(flags), 32'h7);

    // 3: push with simultaneous update, then restore
    drive(1'b1, 4'b1111, 4'b0101, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 4'b1111, 4'b1000, 1'b1, 1'b0, 1'b0, 4'd5);
    chk("t3_flags", 32'(flags), 32'h8);
    chk("t3_depth", 32'(depth), 32'h1);
    drive(1'b1, 4'b1111, 4'b0011, 1'b0, 1'b1, 1'b0, 4'd9);
    chk("t3_pop_flags", 32'(flags), 32'h5);
    chk("t3_empty", 32'(empty), 32'h1);

    // 4: fill, overflow, contents intact, clear
    for (int i = 0; i < SD; i++)
      drive(1'b1, 4'b1111, 4'(i + 10), 1'b1, 1'b0, 1'b0, 4'(i));
    chk("t4_full", 32'(full), 32'h1);
    drive(1'b1, 4'b1111, 4'b0110, 1'b1, 1'b0, 1'b0, 4'd10);
    chk("t4_depth", 32'(depth), 32'h4);
    chk("t4_ovf", 32'(err_overflow), 32'h1);
    chk("t4_upd", 32'(flags), 32'h6);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 4'd0);
    chk("t4_clr", 32'(err_overflow), 32'h0);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 4'd4);
    chk("t4_top", 32'(flags), 32'hC);
    for (int i = 0; i < SD - 1; i++) idle(4'd0);
    for (int i = 0; i < SD - 1; i++)
      drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 4'(i + 6));
    chk("t4_bottom", 32'(flags), 32'h5);

    // 5: underflow with update, error vs clear, push+pop cancel
    drive(1'b1, 4'b1111, 4'b0010, 1'b0, 1'b1, 1'b0, 4'd3);
    chk("t5_unf", 32'(err_underflow), 32'h1);
    chk("t5_flags", 32'(flags), 32'h2);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 4'd0);
    chk("t5_set_wins", 32'(err_underflow), 32'h1);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 4'd0);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 4'd0);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0, 4'd1);
    chk("t5_pp_depth", 32'(depth), 32'h2);
    chk("t5_pp_err", 32'({err_overflow, err_underflow}), 32'h0);
    chk("t5_pp_flags", 32'(flags), 32'h3);

    // 6: signed conditions with S=1 V=0 Z=0, then async reset
    drive(1'b1, 4'b1111, 4'b1000, 1'b0, 1'b0, 1'b0, 4'd12);
    chk("t6_lt", 32'(cond_true), 32'h1);
    cond = 4'd11; #1 chk("t6_ge", 32'(cond_true), 32'h0);
    cond = 4'd13; #1 chk("t6_gt", 32'(cond_true), 32'h0);
    cond = 4'd14; #1 chk("t6_le", 32'(cond_true), 32'h1);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 4'd7);
    for (int i = 0; i < 2; i++)
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 4'd8);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 4'd13);
    chk("t6_ovf_pre", 32'(err_overflow), 32'h1);
    drive(1'b1, 4'b1111, 4'b0111, 1'b0, 1'b0, 1'b0, 4'd0);
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_flags", 32'(flags), 32'h0);
    chk("t6_rst_depth", 32'(depth), 32'h0);
    chk("t6_rst_stat", 32'({full, empty, err_overflow, err_underflow}), 32'h4);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(4'd0);
    idle(4'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
